// File: rtl/clk_gate_pkg.sv
// Shared types and constants for the per-unit clock-gating controller.
package clk_gate_pkg;

  // Per-unit gating state. CG_RUN is the reset state and has encoding 0.
  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_GATED = 2'd1,
    CG_WAKE  = 2'd2
  } cg_state_t;

  // Value of every clock enable while reset is asserted (all units clocked).
  localparam logic CG_RST_EN = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or above
// ptr, wrapping around. The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] w_idx;
  logic          w_found;

  // Scan N positions starting at ptr; the first asserted request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_idx = PW'((int'(ptr) + i) % N);
      if (en && !w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Per-unit clock-gating controller. Each unit runs a RUN/GATED/WAKE FSM;
// idle units are gated after a programmable idle streak, and gated units
// with pending work are woken one at a time through a round-robin arbiter.
//
// Request/grant semantics: a unit raises w_pend while it is GATED and has a
// wake reason. w_gnt is valid only in cycles where no unit is in WAKE; a
// granted unit moves to WAKE on the next edge, which drops its request. A
// request held without grant simply waits; nothing is queued or lost.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int NUNITS = 4,
  parameter int IDLE_W = 8,
  parameter int LAT_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDLE_W-1:0]   cfg_idle_thresh,
  input  logic [LAT_W-1:0]    cfg_wake_lat,
  input  logic                force_on,
  input  logic [NUNITS-1:0]   unit_busy,
  input  logic [NUNITS-1:0]   wake_req,
  output logic [NUNITS-1:0]   clk_en,
  output logic [NUNITS-1:0]   gated,
  output logic [NUNITS-1:0]   wake_ack,
  output logic [2*NUNITS-1:0] dbg_state,
  output logic [((NUNITS > 1) ? $clog2(NUNITS) : 1)-1:0] dbg_rr_ptr
);

  localparam int PTR_W = (NUNITS > 1) ? $clog2(NUNITS) : 1;

  logic [NUNITS-1:0] w_pend;
  logic [NUNITS-1:0] w_in_wake;
  logic [NUNITS-1:0] w_gnt;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic              w_arb_en;
  logic [LAT_W-1:0]  w_lat_load;

  // A zero wake latency still clocks the unit for one cycle.
  assign w_lat_load = (cfg_wake_lat == '0) ? LAT_W'(1) : cfg_wake_lat;

  // Only one unit may be waking at a time to bound inrush current.
  assign w_arb_en  = ~(|w_in_wake);
  assign w_ptr_nxt = PTR_W'((int'(w_gnt_idx) + 1) % NUNITS);

  rr_arbiter #(.N(NUNITS), .PW(PTR_W)) u_arb (
    .req     (w_pend),
    .ptr     (r_rr_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // Round-robin pointer advances past each granted unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (|w_gnt) begin
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  assign dbg_rr_ptr = r_rr_ptr;

  for (genvar u = 0; u < NUNITS; u++) begin : g_unit
    cg_state_t          r_state;
    cg_state_t          w_state_nxt;
    logic [IDLE_W-1:0]  r_idle_cnt;
    logic [IDLE_W-1:0]  w_idle_nxt;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [LAT_W-1:0]   w_lat_nxt;
    logic               w_idle;
    logic               w_hit;
    logic               w_ack_nxt;
    logic               r_clk_en;
    logic               r_gated;
    logic               r_wake_ack;

    assign w_idle = !unit_busy[u] && !wake_req[u];
    // True when this cycle completes (or passes) the threshold idle streak.
    assign w_hit  = ({1'b0, r_idle_cnt} + (IDLE_W + 1)'(1)) >= {1'b0, cfg_idle_thresh};

    assign w_pend[u]    = (r_state == CG_GATED) && (wake_req[u] || unit_busy[u] || force_on);
    assign w_in_wake[u] = (r_state == CG_WAKE);

    // Next-state, counter and ack-pulse logic for one unit.
    always_comb begin
      w_state_nxt = r_state;
      w_idle_nxt  = r_idle_cnt;
      w_lat_nxt   = r_lat_cnt;
      w_ack_nxt   = 1'b0;
      case (r_state)
        CG_RUN: begin
          if (w_idle) begin
            w_idle_nxt = (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + IDLE_W'(1);
            if ((cfg_idle_thresh != '0) && !force_on && w_hit) begin
              w_state_nxt = CG_GATED;
              w_idle_nxt  = '0;
            end
          end else begin
            w_idle_nxt = '0;
          end
        end
        CG_GATED: begin
          w_idle_nxt = '0;
          if (w_gnt[u]) begin
            w_state_nxt = CG_WAKE;
            w_lat_nxt   = w_lat_load;
          end
        end
        CG_WAKE: begin
          w_idle_nxt = '0;
          if (r_lat_cnt <= LAT_W'(1)) begin
            w_state_nxt = CG_RUN;
            w_lat_nxt   = '0;
            w_ack_nxt   = 1'b1;
          end else begin
            w_lat_nxt = r_lat_cnt - LAT_W'(1);
          end
        end
        default: begin
          w_state_nxt = CG_RUN;
          w_idle_nxt  = '0;
          w_lat_nxt   = '0;
        end
      endcase
    end

    // State, counters and registered outputs; outputs follow the next state
    // so the gating cells see a clean flop output.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state    <= CG_RUN;
        r_idle_cnt <= '0;
        r_lat_cnt  <= '0;
        r_clk_en   <= CG_RST_EN;
        r_gated    <= 1'b0;
        r_wake_ack <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_idle_cnt <= w_idle_nxt;
        r_lat_cnt  <= w_lat_nxt;
        r_clk_en   <= (w_state_nxt != CG_GATED);
        r_gated    <= (w_state_nxt == CG_GATED);
        r_wake_ack <= w_ack_nxt;
      end
    end

    assign clk_en[u]          = r_clk_en;
    assign gated[u]           = r_gated;
    assign wake_ack[u]        = r_wake_ack;
    assign dbg_state[2*u +: 2] = r_state;
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: a table of single-cycle vectors plus hand-written
// multi-cycle sequences, all checked through an expected-output queue.
module tb_clk_gate_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] cfg_idle_thresh;
  logic [2:0] cfg_wake_lat;
  logic       force_on;
  logic [3:0] unit_busy;
  logic [3:0] wake_req;
  logic [3:0] clk_en;
  logic [3:0] gated;
  logic [3:0] wake_ack;
  logic [7:0] dbg_state;
  logic [1:0] dbg_rr_ptr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic       r;
    logic [3:0] busy;
    logic [3:0] wake;
    logic [3:0] e_en;
    logic [3:0] e_g;
    logic [3:0] e_a;
  } vec_t;

  vec_t tbl[11];

  clk_gate_ctrl #(.NUNITS(4), .IDLE_W(8), .LAT_W(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_idle_thresh (cfg_idle_thresh),
    .cfg_wake_lat    (cfg_wake_lat),
    .force_on        (force_on),
    .unit_busy       (unit_busy),
    .wake_req        (wake_req),
    .clk_en          (clk_en),
    .gated           (gated),
    .wake_ack        (wake_ack),
    .dbg_state       (dbg_state),
    .dbg_rr_ptr      (dbg_rr_ptr)
  );

  // Clock and initial input values.
  initial begin
    clk             = 1'b0;
    rst             = 1'b1;
    cfg_idle_thresh = 8'd8;
    cfg_wake_lat    = 3'd1;
    force_on        = 1'b0;
    unit_busy       = 4'hF;
    wake_req        = 4'h0;
  end
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] busy, input logic [3:0] wake,
                              input logic [3:0] e_en, input logic [3:0] e_g, input logic [3:0] e_a);
    vec_t v;
    v.r = r; v.busy = busy; v.wake = wake; v.e_en = e_en; v.e_g = e_g; v.e_a = e_a;
    return v;
  endfunction

  // Pop the oldest expectation and compare it with the outputs now visible.
  task automatic check_out();
    logic [11:0] e;
    string       nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    n_tests++;
    if ({clk_en, gated, wake_ack} !== e) begin
      n_fail++;
      $display("FAIL %s: got en=%b gated=%b ack=%b, want en=%b gated=%b ack=%b",
               nm, clk_en, gated, wake_ack, e[11:8], e[7:4], e[3:0]);
    end
  endtask

  task automatic check_ptr(input logic [1:0] want, input string nm);
    n_tests++;
    if (dbg_rr_ptr !== want) begin
      n_fail++;
      $display("FAIL %s: got rr_ptr=%0d, want %0d", nm, dbg_rr_ptr, want);
    end
  endtask

  // Drive one cycle of inputs, record the outputs expected after the next
  // edge, then check them 1ns after that edge.
  task automatic step(input logic r, input logic [3:0] busy, input logic [3:0] wake,
                      input logic f, input logic [3:0] e_en, input logic [3:0] e_g,
                      input logic [3:0] e_a, input string nm);
    rst       = r;
    unit_busy = busy;
    wake_req  = wake;
    force_on  = f;
    exp_q.push_back({e_en, e_g, e_a});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset();
    step(1'b1, 4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, "reset");
  endtask

  initial begin
    logic [3:0] en;
    logic [3:0] ack;

    // Basic table: thresh=2, lat=1, unit 0 gates and wakes twice.
    tbl[0]  = mk(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0);
    tbl[1]  = mk(1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0);
    tbl[2]  = mk(1'b0, 4'hE, 4'h0, 4'hF, 4'h0, 4'h0);
    tbl[3]  = mk(1'b0, 4'hE, 4'h0, 4'hE, 4'h1, 4'h0);
    tbl[4]  = mk(1'b0, 4'hE, 4'h0, 4'hE, 4'h1, 4'h0);
    tbl[5]  = mk(1'b0, 4'hE, 4'h1, 4'hF, 4'h0, 4'h0);
    tbl[6]  = mk(1'b0, 4'hE, 4'h0, 4'hF, 4'h0, 4'h1);
    tbl[7]  = mk(1'b0, 4'hE, 4'h0, 4'hF, 4'h0, 4'h0);
    tbl[8]  = mk(1'b0, 4'hE, 4'h0, 4'hE, 4'h1, 4'h0);
    tbl[9]  = mk(1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0);
    tbl[10] = mk(1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h1);

    @(posedge clk);
    #1;
    cfg_idle_thresh = 8'd2;
    cfg_wake_lat    = 3'd1;
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].busy, tbl[i].wake, 1'b0, tbl[i].e_en, tbl[i].e_g, tbl[i].e_a,
           $sformatf("tbl_%0d", i));
    end
    check_ptr(2'd1, "tbl_rr_ptr");

    // Idle threshold 8: unit 0 gated from the 8th cycle, others stay enabled.
    cfg_idle_thresh = 8'd8;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k < 7) step(1'b0, 4'hE, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, $sformatf("t1_k%0d", k));
      else       step(1'b0, 4'hE, 4'h0, 1'b0, 4'hE, 4'h1, 4'h0, $sformatf("t1_k%0d", k));
    end

    // Threshold lowered mid-count: gate on the next idle cycle.
    cfg_idle_thresh = 8'd8;
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 4'hE, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, $sformatf("tch_k%0d", k));
    cfg_idle_thresh = 8'd3;
    step(1'b0, 4'hE, 4'h0, 1'b0, 4'hE, 4'h1, 4'h0, "tch_gate");

    // Threshold 0: gating disabled even when everything is idle.
    cfg_idle_thresh = 8'd0;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      cfg_wake_lat = 3'($urandom_range(0, 7));
      step(1'b0, 4'h0, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, $sformatf("t2_k%0d", k));
    end

    // Wake latency 3 on unit 2.
    cfg_idle_thresh = 8'd8;
    cfg_wake_lat    = 3'd3;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k < 7) step(1'b0, 4'hB, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, $sformatf("t3_g%0d", k));
      else       step(1'b0, 4'hB, 4'h0, 1'b0, 4'hB, 4'h4, 4'h0, $sformatf("t3_g%0d", k));
    end
    step(1'b0, 4'hB, 4'h4, 1'b0, 4'hF, 4'h0, 4'h0, "t3_n1");
    step(1'b0, 4'hB, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, "t3_n2");
    step(1'b0, 4'hB, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, "t3_n3");
    step(1'b0, 4'hB, 4'h0, 1'b0, 4'hF, 4'h0, 4'h4, "t3_n4_ack");
    step(1'b0, 4'hB, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, "t3_n5");

    // Two requests: unit 1 then unit 3, serialised by the arbiter.
    cfg_wake_lat = 3'd3;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k < 7) step(1'b0, 4'h5, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, $sformatf("t4_g%0d", k));
      else       step(1'b0, 4'h5, 4'h0, 1'b0, 4'h5, 4'hA, 4'h0, $sformatf("t4_g%0d", k));
    end
    step(1'b0, 4'h5, 4'hA, 1'b0, 4'h7, 4'h8, 4'h0, "t4_n1");
    check_ptr(2'd2, "t4_ptr_after_u1");
    step(1'b0, 4'h5, 4'hA, 1'b0, 4'h7, 4'h8, 4'h0, "t4_n2");
    step(1'b0, 4'h5, 4'hA, 1'b0, 4'h7, 4'h8, 4'h0, "t4_n3");
    step(1'b0, 4'h5, 4'hA, 1'b0, 4'h7, 4'h8, 4'h2, "t4_n4_ack1");
    step(1'b0, 4'h5, 4'hA, 1'b0, 4'hF, 4'h0, 4'h0, "t4_n5_en3");
    step(1'b0, 4'h5, 4'hA, 1'b0, 4'hF, 4'h0, 4'h0, "t4_n6");
    step(1'b0, 4'h5, 4'hA, 1'b0, 4'hF, 4'h0, 4'h0, "t4_n7");
    step(1'b0, 4'h5, 4'hA, 1'b0, 4'hF, 4'h0, 4'h8, "t4_n8_ack3");
    check_ptr(2'd0, "t4_ptr_end");

    // force_on with every unit gated: staggered wakes, no re-gating.
    cfg_wake_lat = 3'd1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k < 7) step(1'b0, 4'h0, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, $sformatf("t5_g%0d", k));
      else       step(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, $sformatf("t5_g%0d", k));
    end
    for (int j = 0; j < 20; j++) begin
      for (int u = 0; u < 4; u++) begin
        en[u]  = (j >= 2 * u);
        ack[u] = (j == 2 * u + 1);
      end
      step(1'b0, 4'h0, 4'h0, 1'b1, en, ~en, ack, $sformatf("t5_j%0d", j));
    end

    // Reset while unit 1 is waking: no ack afterwards.
    cfg_wake_lat = 3'd3;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k < 7) step(1'b0, 4'hD, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, $sformatf("t6_g%0d", k));
      else       step(1'b0, 4'hD, 4'h0, 1'b0, 4'hD, 4'h2, 4'h0, $sformatf("t6_g%0d", k));
    end
    step(1'b0, 4'hD, 4'h2, 1'b0, 4'hF, 4'h0, 4'h0, "t6_wake");
    step(1'b1, 4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, "t6_rst");
    n_tests++;
    if (dbg_state !== 8'h00) begin
      n_fail++;
      $display("FAIL t6_state: got dbg_state=%h, want 00", dbg_state);
    end
    for (int k = 0; k < 6; k++) step(1'b0, 4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, $sformatf("t6_post%0d", k));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
